bullet_collision_scanner: RTL

Consumes the bullet, enemy and player positions/states produced by the bullet generator/mover and resolves hits once per scan request. Scans sequentially, one bullet/target pair per clock, to keep the comparator count at one. Returns kill/clear masks that the generator applies to its state vectors on the next frame. Sits between the bullet generator/mover and the game-state/score logic.

---
 rtl/bullet_collision_scanner.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/bullet_collision_scanner.sv
// bullet_collision_scanner
// Resolves player-bullet/enemy and enemy-bullet/player hits once per scan
// request. A single box-overlap comparator is time-shared: one bullet/target
// pair is tested per clock. Kill/clear masks are returned for the bullet
// generator to apply on the next frame, plus a player-hit flag and kill count.
module bullet_collision_scanner #(
   parameter int MAX_ENEMY         = 15,
   parameter int MAX_PLAYER_BULLET = 15,
   parameter int MAX_ENEMY_BULLET  = 30,
   parameter int BULLET_WIDTH      = 6,
   parameter int BULLET_HEIGHT     = 20,
   parameter int ENEMY_WIDTH       = 32,
   parameter int ENEMY_HEIGHT      = 24,
   parameter int PLAYER_WIDTH      = 26,
   parameter int PLAYER_HEIGHT     = 16
) (
   input  logic                            i_Clk,
   input  logic                            i_Rst,
   input  logic                            i_Start,
   input  logic [MAX_ENEMY-1:0]            i_EnemyState,
   input  logic [19*MAX_ENEMY-1:0]         i_EnemyPos,
   input  logic                            i_PlayerState,
   input  logic [18:0]                     i_PlayerPos,
   input  logic [MAX_PLAYER_BULLET-1:0]    i_PlayerBulletState,
   input  logic [19*MAX_PLAYER_BULLET-1:0] i_PlayerBulletPos,
   input  logic [MAX_ENEMY_BULLET-1:0]     i_EnemyBulletState,
   input  logic [19*MAX_ENEMY_BULLET-1:0]  i_EnemyBulletPos,
   output logic                            o_Busy,
   output logic                            o_Done,
   output logic [MAX_ENEMY-1:0]            o_EnemyKill,
   output logic [MAX_PLAYER_BULLET-1:0]    o_PlayerBulletClear,
   output logic [MAX_ENEMY_BULLET-1:0]     o_EnemyBulletClear,
   output logic                            o_PlayerHit,
   output logic [3:0]                      o_KillCnt
);

   localparam int EIW = (MAX_ENEMY > 1)         ? $clog2(MAX_ENEMY)         : 1;
   localparam int PIW = (MAX_PLAYER_BULLET > 1) ? $clog2(MAX_PLAYER_BULLET) : 1;
   localparam int BIW = (MAX_ENEMY_BULLET > 1)  ? $clog2(MAX_ENEMY_BULLET)  : 1;

   localparam logic [EIW-1:0] LAST_E  = EIW'(MAX_ENEMY - 1);
   localparam logic [PIW-1:0] LAST_PB = PIW'(MAX_PLAYER_BULLET - 1);
   localparam logic [BIW-1:0] LAST_EB = BIW'(MAX_ENEMY_BULLET - 1);

   localparam logic [9:0] BUL_W    = 10'(BULLET_WIDTH);
   localparam logic [8:0] BUL_H    = 9'(BULLET_HEIGHT);
   localparam logic [9:0] ENEMY_W  = 10'(ENEMY_WIDTH);
   localparam logic [8:0] ENEMY_H  = 9'(ENEMY_HEIGHT);
   localparam logic [9:0] PLAYER_W = 10'(PLAYER_WIDTH);
   localparam logic [8:0] PLAYER_H = 9'(PLAYER_HEIGHT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN_P = 2'd1,
      SCAN_E = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                       state;
   logic [EIW-1:0]               eIdx;
   logic [PIW-1:0]               pbIdx;
   logic [BIW-1:0]               ebIdx;
   logic [MAX_ENEMY-1:0]         enemyAlive;
   logic                         playerAlive;
   logic [MAX_PLAYER_BULLET-1:0] pbActive;
   logic [MAX_ENEMY_BULLET-1:0]  ebActive;

   logic [18:0] enemyPos [MAX_ENEMY];
   logic [18:0] pbPos    [MAX_PLAYER_BULLET];
   logic [18:0] ebPos    [MAX_ENEMY_BULLET];

   logic [18:0] bulPos;
   logic [18:0] tgtPos;
   logic [9:0]  tgtW;
   logic [8:0]  tgtH;
   logic        overlap;

   // Strict AABB overlap; sums are one bit wider so edges near the screen
   // limit cannot wrap. Equality (touching edges) is not a hit.
   function automatic logic boxOverlap(
      input logic [9:0] ax, input logic [8:0] ay,
      input logic [9:0] aw, input logic [8:0] ah,
      input logic [9:0] bx, input logic [8:0] by,
      input logic [9:0] bw, input logic [8:0] bh
   );
      logic [10:0] axE, bxE, axEnd, bxEnd;
      logic [9:0]  ayE, byE, ayEnd, byEnd;
      axE   = {1'b0, ax};
      bxE   = {1'b0, bx};
      axEnd = {1'b0, ax} + {1'b0, aw};
      bxEnd = {1'b0, bx} + {1'b0, bw};
      ayE   = {1'b0, ay};
      byE   = {1'b0, by};
      ayEnd = {1'b0, ay} + {1'b0, ah};
      byEnd = {1'b0, by} + {1'b0, bh};
      return (axE < bxEnd) && (bxE < axEnd) && (ayE < byEnd) && (byE < ayEnd);
   endfunction

   // Unpack the flat position buses into per-slot entries
   genvar gk;
   generate
      for (gk = 0; gk < MAX_ENEMY; gk++) begin : g_enemyPos
         assign enemyPos[gk] = i_EnemyPos[19*gk +: 19];
      end
      for (gk = 0; gk < MAX_PLAYER_BULLET; gk++) begin : g_pbPos
         assign pbPos[gk] = i_PlayerBulletPos[19*gk +: 19];
      end
      for (gk = 0; gk < MAX_ENEMY_BULLET; gk++) begin : g_ebPos
         assign ebPos[gk] = i_EnemyBulletPos[19*gk +: 19];
      end
   endgenerate

   // Steer the current bullet/target pair into the single shared comparator
   always_comb begin
      bulPos = 19'd0;
      tgtPos = 19'd0;
      tgtW   = ENEMY_W;
      tgtH   = ENEMY_H;
      if (state == SCAN_E) begin
         bulPos = ebPos[ebIdx];
         tgtPos = i_PlayerPos;
         tgtW   = PLAYER_W;
         tgtH   = PLAYER_H;
      end else begin
         bulPos = pbPos[pbIdx];
         tgtPos = enemyPos[eIdx];
         tgtW   = ENEMY_W;
         tgtH   = ENEMY_H;
      end
      overlap = boxOverlap(bulPos[18:9], bulPos[8:0], BUL_W, BUL_H,
                           tgtPos[18:9], tgtPos[8:0], tgtW, tgtH);
   end

   // Scan sequencer: shadow state capture, pairwise stepping and result masks
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state               <= IDLE;
         eIdx                <= '0;
         pbIdx               <= '0;
         ebIdx               <= '0;
         enemyAlive          <= '0;
         playerAlive         <= 1'b0;
         pbActive            <= '0;
         ebActive            <= '0;
         o_Busy              <= 1'b0;
         o_Done              <= 1'b0;
         o_EnemyKill         <= '0;
         o_PlayerBulletClear <= '0;
         o_EnemyBulletClear  <= '0;
         o_PlayerHit         <= 1'b0;
         o_KillCnt           <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               o_Done <= 1'b0;
               if (i_Start) begin
                  enemyAlive          <= i_EnemyState;
                  playerAlive         <= i_PlayerState;
                  pbActive            <= i_PlayerBulletState;
                  ebActive            <= i_EnemyBulletState;
                  o_EnemyKill         <= '0;
                  o_PlayerBulletClear <= '0;
                  o_EnemyBulletClear  <= '0;
                  o_PlayerHit         <= 1'b0;
                  o_KillCnt           <= 4'd0;
                  pbIdx               <= '0;
                  eIdx                <= '0;
                  ebIdx               <= '0;
                  o_Busy              <= 1'b1;
                  state               <= SCAN_P;
               end else begin
                  o_Busy <= 1'b0;
               end
            end

            SCAN_P: begin
               // A bullet step ends on: inactive bullet, first hit, or last enemy
               if (!pbActive[pbIdx] ||
                   (enemyAlive[eIdx] && overlap) ||
                   (eIdx == LAST_E)) begin
                  if (pbActive[pbIdx] && enemyAlive[eIdx] && overlap) begin
                     o_EnemyKill[eIdx]          <= 1'b1;
                     o_PlayerBulletClear[pbIdx] <= 1'b1;
                     enemyAlive[eIdx]           <= 1'b0;
                     o_KillCnt                  <= o_KillCnt + 4'd1;
                  end
                  eIdx <= '0;
                  if (pbIdx == LAST_PB) begin
                     ebIdx <= '0;
                     state <= SCAN_E;
                  end else begin
                     pbIdx <= pbIdx + PIW'(1);
                  end
               end else begin
                  eIdx <= eIdx + EIW'(1);
               end
            end

            SCAN_E: begin
               // Player stays alive for the whole pass so every overlapping bullet clears
               if (playerAlive && ebActive[ebIdx] && overlap) begin
                  o_EnemyBulletClear[ebIdx] <= 1'b1;
                  o_PlayerHit               <= 1'b1;
               end
               if (ebIdx == LAST_EB) begin
                  state <= DONE;
               end else begin
                  ebIdx <= ebIdx + BIW'(1);
               end
            end

            DONE: begin
               o_Done <= 1'b1;
               o_Busy <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               o_Done <= 1'b0;
               o_Busy <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
